mem_req_queue: RTL and testbench
================================

Name: mem_req_queue

Overview:
- Parametrised memory-request issue queue for the next-generation MEM1 stage; sits between address translation and the DCache.
- Accepts translated load/store/LL/SC requests and checks natural alignment, raising ALE.
- Builds the byte select and lane-shifted write data for a DATA_WIDTH bus, owns the LL bit, and buffers up to DEPTH requests.
- Issues requests to the DCache over a valid/ready handshake, decoupling the pipeline from DCache stalls.

Parameters:
- ADDR_WIDTH, 32, physical address width
- DATA_WIDTH, 32, DCache data bus width; 32 or 64 only
- DEPTH, 4, queue entries; power of two, >=2
- PC_WIDTH, 32, width of PC tag carried for debug/difftest

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; drops all queued requests not yet presented to the DCache
- in_valid  in  1  request present
- in_ready  out  1  queue can accept; equals count_o < DEPTH
- in_paddr  in  ADDR_WIDTH  physical address
- in_size  in  2  0=byte 1=half 2=word 3=dword (3 legal only when DATA_WIDTH=64)
- in_we  in  1  store
- in_ll  in  1  LL.W
- in_sc  in  1  SC.W
- in_uncache  in  1  uncached access
- in_wdata  in  DATA_WIDTH  right-aligned store data
- in_pc  in  PC_WIDTH  instruction PC
- ale_o  out  1  combinational: current input is misaligned or has an illegal size
- sc_valid_o  out  1  SC resolved this cycle
- sc_result_o  out  1  SC outcome (1 = success)
- llbit_o  out  1  current LL bit
- llbit_clear_i  in  1  clear LL bit (ERTN/exception)
- dcache_req_valid  out  1  head request valid
- dcache_req_ready  in  1  DCache accepts
- dcache_addr  out  ADDR_WIDTH  request address
- dcache_we  out  1  write
- dcache_sel  out  DATA_WIDTH/8  byte enables
- dcache_wdata  out  DATA_WIDTH  lane-aligned write data
- dcache_size  out  2  access size
- dcache_uncache  out  1  uncached
- dcache_pc  out  PC_WIDTH  PC tag
- count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset:
  - All outputs 0.
  - Queue empty; count_o=0; llbit_o=0; head_committed=0.
- Alignment, with OFS = log2(DATA_WIDTH/8):
  - ale_o=1 if in_valid and any of: size1 with paddr[0]!=0; size2 with paddr[1:0]!=0; size3 with paddr[2:0]!=0; size3 with DATA_WIDTH=32.
  - A misaligned request is never enqueued or resolved. The caller treats it as consumed and raises the exception.
- Accept condition: push = in_valid & in_ready & ~ale_o & ~flush & ~(in_sc & ~llbit_o).
- Encoding on push:
  - bytes = 1<<size.
  - sel = ((1<<bytes)-1) << paddr[OFS-1:0].
  - wdata = (in_wdata masked to bytes) << (8*paddr[OFS-1:0]).
  - Loads carry wdata = 0.
- SC handling:
  - in_sc with llbit_o=0: not enqueued. sc_valid_o=1, sc_result_o=0 that cycle. Resolves even when full, but not during flush.
  - in_sc with llbit_o=1: resolves only on push. sc_valid_o=1, sc_result_o=1, and llbit cleared next cycle.
- LL bit:
  - Set on push of in_ll; cleared on successful SC push or llbit_clear_i.
  - llbit_clear_i wins over a simultaneous set.
- Queue and issue:
  - FIFO with wrap-around head/tail pointers, DEPTH entries; dcache_* outputs driven from the head entry register.
  - dcache_req_valid = count_o>0; latency 1 cycle from push to first valid.
  - No bypass: an empty queue plus a push gives valid on the next cycle.
  - Pop on dcache_req_valid & dcache_req_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: in_ready=0 even if a pop occurs that cycle.
- Stability: once dcache_req_valid=1, the head entry and valid are held until ready. head_committed=1 while valid & ~ready.
- Flush:
  - Next cycle, all entries are removed except the head when head_committed=1 (or when it is being presented this cycle and not popped). Count becomes 1 or 0.
  - If the head pops during flush, the queue is empty.
  - flush does not change llbit_o.

Test Plan:
- DATA_WIDTH=32, push st.b paddr=0x1003 wdata=0xAB -> next cycle dcache_req_valid=1, sel=4'b1000, wdata=0xAB000000, we=1.
- Push ld.h paddr=0x1001 -> ale_o=1, count_o stays 0, no DCache request; ld.w at 0x1004 -> sel=4'b1111.
- DATA_WIDTH=64, DEPTH=4, dcache_req_ready=0, push 4 ld.d at 0x0,0x8,0x10,0x18 -> in_ready=0 and count_o=4. Raise ready -> 4 pops in order, addresses unchanged while valid waits.
- LL at 0x2000 then SC -> llbit_o=1 after the LL, SC pushed with sc_result_o=1, llbit_o=0 after. Second SC -> sc_valid_o=1, sc_result_o=0, nothing enqueued.
- Queue holds 3 entries with head presented and ready=0; assert flush -> count_o=1 next cycle, head addr unchanged; on ready, pop leaves queue empty.
- Assert rst mid-burst with 2 entries queued and llbit=1 -> all outputs 0 immediately, count_o=0, llbit_o=0.

Source files
------------

// File: rtl/mem_req_queue.sv
// mem_req_queue: MEM1 memory-request issue queue between address translation
// and the DCache.
//
// Checks natural alignment of each incoming request (ale_o), encodes byte
// enables and lane-shifted store data for a DATA_WIDTH bus, owns the LL bit,
// resolves SC, and buffers up to DEPTH requests for the DCache.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 drop every queued request the DCache has not seen
//   in_valid/in_ready     request handshake from the pipeline
//   in_paddr, in_size     physical address, size (0=B 1=H 2=W 3=D)
//   in_we/in_ll/in_sc     store / LL.W / SC.W
//   in_uncache, in_wdata  uncached flag, right-aligned store data
//   in_pc                 PC tag for debug/difftest
//   ale_o                 combinational misalignment / illegal size flag
//   sc_valid_o/sc_result_o SC resolved this cycle / its outcome
//   llbit_o, llbit_clear_i current LL bit / clear request (ERTN, exception)
//   dcache_req_valid/ready head request handshake to the DCache
//   dcache_*              head request fields
//   count_o               queue occupancy
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1.
// On the DCache side, once dcache_req_valid is 1 the head entry and valid are
// held unchanged until dcache_req_ready is seen; ready may depend on valid,
// valid never depends on ready.
module mem_req_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_paddr,
  input  logic [1:0]                in_size,
  input  logic                      in_we,
  input  logic                      in_ll,
  input  logic                      in_sc,
  input  logic                      in_uncache,
  input  logic [DATA_WIDTH-1:0]     in_wdata,
  input  logic [PC_WIDTH-1:0]       in_pc,
  output logic                      ale_o,
  output logic                      sc_valid_o,
  output logic                      sc_result_o,
  output logic                      llbit_o,
  input  logic                      llbit_clear_i,
  output logic                      dcache_req_valid,
  input  logic                      dcache_req_ready,
  output logic [ADDR_WIDTH-1:0]     dcache_addr,
  output logic                      dcache_we,
  output logic [DATA_WIDTH/8-1:0]   dcache_sel,
  output logic [DATA_WIDTH-1:0]     dcache_wdata,
  output logic [1:0]                dcache_size,
  output logic                      dcache_uncache,
  output logic [PC_WIDTH-1:0]       dcache_pc,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int SELW = DATA_WIDTH / 8;
  localparam int OFS  = $clog2(SELW);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [SELW-1:0]       sel;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            size;
    logic                  uncache;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          new_entry;
  entry_t          head_entry;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_next;
  logic [CW-1:0]   count;
  logic            llbit;
  logic            head_committed;

  logic            misaligned;
  logic            full;
  logic            valid;
  logic            push;
  logic            pop;
  logic            sc_fail;
  logic            keep_head;
  logic [OFS-1:0]  off;
  logic [SELW-1:0] base_sel;
  logic [DATA_WIDTH-1:0] byte_mask;

  // Size 3 is only legal on a 64-bit bus.
  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_paddr[0];
      2'd2:    misaligned = |in_paddr[1:0];
      default: misaligned = (DATA_WIDTH == 32) | (|in_paddr[2:0]);
    endcase
  end

  assign ale_o    = ~rst & in_valid & misaligned;
  assign full     = (count == CW'(DEPTH));
  assign in_ready = ~rst & ~full;
  assign valid    = (count != '0);
  assign pop      = valid & dcache_req_ready;

  assign push = in_valid & in_ready & ~ale_o & ~flush & ~(in_sc & ~llbit);

  // A failing SC needs no queue slot, so it resolves even when full.
  assign sc_fail     = ~rst & in_valid & in_sc & ~llbit & ~ale_o & ~flush;
  assign sc_valid_o  = sc_fail | (push & in_sc);
  assign sc_result_o = push & in_sc;

  // Encoding: byte enables for the access size, shifted to the lane offset.
  assign off = in_paddr[OFS-1:0];

  always_comb begin
    base_sel = '0;
    case (in_size)
      2'd0:    base_sel = SELW'(8'h01);
      2'd1:    base_sel = SELW'(8'h03);
      2'd2:    base_sel = SELW'(8'h0F);
      default: base_sel = SELW'(8'hFF);
    endcase
  end

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < SELW; i++) begin
      byte_mask[8*i +: 8] = {8{base_sel[i]}};
    end
  end

  always_comb begin
    new_entry         = '0;
    new_entry.addr    = in_paddr;
    new_entry.we      = in_we;
    new_entry.sel     = base_sel << off;
    new_entry.wdata   = in_we ? ((in_wdata & byte_mask) << {off, 3'b000}) : '0;
    new_entry.size    = in_size;
    new_entry.uncache = in_uncache;
    new_entry.pc      = in_pc;
  end

  // On flush the head survives only if the DCache has already seen it and
  // is not taking it this cycle; head_committed covers the held case.
  assign keep_head = (head_committed | valid) & ~dcache_req_ready;
  assign head_next = pop ? head + 1'b1 : head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      llbit          <= 1'b0;
      head_committed <= 1'b0;
    end else begin
      head_committed <= valid & ~dcache_req_ready;

      if (llbit_clear_i)          llbit <= 1'b0;
      else if (push & in_sc)      llbit <= 1'b0;
      else if (push & in_ll)      llbit <= 1'b1;

      if (flush) begin
        head  <= head_next;
        tail  <= keep_head ? head + 1'b1 : head_next;
        count <= keep_head ? CW'(1) : '0;
      end else begin
        head <= head_next;
        if (push) tail <= tail + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: outputs are masked by valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= new_entry;
  end

  assign head_entry       = mem[head];
  assign dcache_req_valid = valid;
  assign dcache_addr      = valid ? head_entry.addr    : '0;
  assign dcache_we        = valid ? head_entry.we      : 1'b0;
  assign dcache_sel       = valid ? head_entry.sel     : '0;
  assign dcache_wdata     = valid ? head_entry.wdata   : '0;
  assign dcache_size      = valid ? head_entry.size    : '0;
  assign dcache_uncache   = valid ? head_entry.uncache : 1'b0;
  assign dcache_pc        = valid ? head_entry.pc      : '0;
  assign count_o          = count;
  assign llbit_o          = llbit;

endmodule

// File: tb/tb_mem_req_queue.sv
// Testbench for mem_req_queue (64-bit bus, DEPTH=4): directed scenarios plus
// randomized traffic checked every cycle against a queue-based reference.
module tb_mem_req_queue;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int PCW   = 32;
  localparam int SW    = DW / 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  in_paddr;
  logic [1:0]     in_size;
  logic           in_we, in_ll, in_sc, in_uncache;
  logic [DW-1:0]  in_wdata;
  logic [PCW-1:0] in_pc;
  logic           ale_o, sc_valid_o, sc_result_o, llbit_o, llbit_clear_i;
  logic           dcache_req_valid, dcache_req_ready;
  logic [AW-1:0]  dcache_addr;
  logic           dcache_we;
  logic [SW-1:0]  dcache_sel;
  logic [DW-1:0]  dcache_wdata;
  logic [1:0]     dcache_size;
  logic           dcache_uncache;
  logic [PCW-1:0] dcache_pc;
  logic [CW-1:0]  count_o;

  mem_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .PC_WIDTH(PCW)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_paddr(in_paddr), .in_size(in_size),
    .in_we(in_we), .in_ll(in_ll), .in_sc(in_sc), .in_uncache(in_uncache),
    .in_wdata(in_wdata), .in_pc(in_pc),
    .ale_o(ale_o), .sc_valid_o(sc_valid_o), .sc_result_o(sc_result_o),
    .llbit_o(llbit_o), .llbit_clear_i(llbit_clear_i),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_sel(dcache_sel),
    .dcache_wdata(dcache_wdata), .dcache_size(dcache_size),
    .dcache_uncache(dcache_uncache), .dcache_pc(dcache_pc), .count_o(count_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  typedef struct {
    logic [AW-1:0]  addr;
    logic           we;
    logic [SW-1:0]  sel;
    logic [DW-1:0]  wdata;
    logic [1:0]     size;
    logic           unc;
    logic [PCW-1:0] pc;
  } ent_t;

  ent_t exp_q[$];
  bit   llb_m;
  int   n_checks = 0;
  int   n_pass   = 0;

  bit   e_ale, e_rdy, e_push, e_scf;
  ent_t e_ent;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference rules
  function automatic bit misaligned(input logic [AW-1:0] a, input logic [1:0] s);
    int bytes = 1 << s;
    if (s == 2'd3 && DW == 32) return 1'b1;
    return (int'(a[3:0]) % bytes) != 0;
  endfunction

  // Byte b of the right-aligned store data lands in lane (offset + b).
  function automatic ent_t make_ent();
    ent_t e;
    int bytes = 1 << in_size;
    int off   = int'(in_paddr[3:0]) % SW;
    e.addr  = in_paddr;
    e.we    = in_we;
    e.size  = in_size;
    e.unc   = in_uncache;
    e.pc    = in_pc;
    e.sel   = '0;
    e.wdata = '0;
    for (int b = 0; b < bytes; b++) begin
      e.sel[off + b] = 1'b1;
      if (in_we) e.wdata[8*(off + b) +: 8] = in_wdata[8*b +: 8];
    end
    return e;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    in_valid = 0; in_paddr = '0; in_size = '0; in_we = 0; in_ll = 0; in_sc = 0;
    in_uncache = 0; in_wdata = '0; in_pc = '0; flush = 0; llbit_clear_i = 0;
  endtask

  task automatic drive_req(input logic [AW-1:0] a, input logic [1:0] s, input bit we,
                           input bit ll, input bit sc, input logic [DW-1:0] d);
    in_valid = 1; in_paddr = a; in_size = s; in_we = we; in_ll = ll; in_sc = sc;
    in_uncache = a[12]; in_wdata = d; in_pc = 32'h8000_0000 | a;
  endtask

  // One clock: check all outputs mid-cycle against the model, then advance
  // the model on the rising edge. Entered and left at posedge+1.
  task automatic cycle();
    @(negedge clk);
    e_ale  = in_valid && misaligned(in_paddr, in_size);
    e_rdy  = exp_q.size() < DEPTH;
    e_push = in_valid && e_rdy && !e_ale && !flush && !(in_sc && !llb_m);
    e_scf  = in_valid && in_sc && !llb_m && !e_ale && !flush;
    e_ent  = make_ent();
    chk("ale", ale_o, e_ale);
    chk("in_ready", in_ready, e_rdy);
    chk("sc_valid", sc_valid_o, e_scf || (e_push && in_sc));
    chk("sc_result", sc_result_o, e_push && in_sc);
    chk("llbit", llbit_o, llb_m);
    chk("count", count_o, exp_q.size());
    chk("req_valid", dcache_req_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("addr", dcache_addr, exp_q[0].addr);
      chk("we", dcache_we, exp_q[0].we);
      chk("sel", dcache_sel, exp_q[0].sel);
      chk("wdata", dcache_wdata, exp_q[0].wdata);
      chk("size", dcache_size, exp_q[0].size);
      chk("uncache", dcache_uncache, exp_q[0].unc);
      chk("pc", dcache_pc, exp_q[0].pc);
    end
    @(posedge clk);
    if (flush) begin
      if (exp_q.size() > 0 && !dcache_req_ready) begin
        ent_t h = exp_q[0];
        exp_q.delete();
        exp_q.push_back(h);
      end else begin
        exp_q.delete();
      end
    end else begin
      if (exp_q.size() > 0 && dcache_req_ready) void'(exp_q.pop_front());
      if (e_push) exp_q.push_back(e_ent);
    end
    if (llbit_clear_i)            llb_m = 0;
    else if (e_push && in_sc)     llb_m = 0;
    else if (e_push && in_ll)     llb_m = 1;
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    dcache_req_ready = 1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    chk("drain_count", count_o, 0);
    dcache_req_ready = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_ale"}, ale_o, 0);
    chk({tag, "_sc_valid"}, sc_valid_o, 0);
    chk({tag, "_sc_result"}, sc_result_o, 0);
    chk({tag, "_llbit"}, llbit_o, 0);
    chk({tag, "_req_valid"}, dcache_req_valid, 0);
    chk({tag, "_addr"}, dcache_addr, 0);
    chk({tag, "_we"}, dcache_we, 0);
    chk({tag, "_sel"}, dcache_sel, 0);
    chk({tag, "_wdata"}, dcache_wdata, 0);
    chk({tag, "_size"}, dcache_size, 0);
    chk({tag, "_uncache"}, dcache_uncache, 0);
    chk({tag, "_pc"}, dcache_pc, 0);
    chk({tag, "_count"}, count_o, 0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1;
    idle_inputs();
    dcache_req_ready = 0;
    #1;
    check_all_zero(tag);
    exp_q.delete();
    llb_m = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    dcache_req_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset("reset");

    // st.b at 0x1003: lane 3 on the 64-bit bus
    drive_req(32'h1003, 2'd0, 1, 0, 0, 64'hAB);
    cycle();
    idle_inputs();
    chk("stb_valid", dcache_req_valid, 1);
    chk("stb_sel", dcache_sel, 8'h08);
    chk("stb_wdata", dcache_wdata, 64'hAB00_0000);
    chk("stb_we", dcache_we, 1);
    drain();

    // Misaligned ld.h is not enqueued; ld.w at 0x1004 uses the upper word
    drive_req(32'h1001, 2'd1, 0, 0, 0, '0);
    #1 chk("ldh_ale", ale_o, 1);
    cycle();
    idle_inputs();
    chk("ldh_count", count_o, 0);
    chk("ldh_novalid", dcache_req_valid, 0);
    drive_req(32'h1004, 2'd2, 0, 0, 0, 64'hFFFF);
    cycle();
    idle_inputs();
    chk("ldw_sel", dcache_sel, 8'hF0);
    chk("ldw_wdata", dcache_wdata, 0);
    drain();

    // Fill with 4 ld.d while the DCache stalls, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive_req(32'(i * 8), 2'd3, 0, 0, 0, '0);
      cycle();
    end
    idle_inputs();
    chk("full_ready", in_ready, 0);
    chk("full_count", count_o, 4);
    drive_req(32'h40, 2'd3, 0, 0, 0, '0);
    cycle();
    cycle();
    idle_inputs();
    chk("stall_addr", dcache_addr, 0);
    dcache_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("order_addr", dcache_addr, 32'(i * 8));
      cycle();
    end
    chk("order_empty", dcache_req_valid, 0);
    dcache_req_ready = 0;

    // LL / SC
    dcache_req_ready = 1;
    drive_req(32'h2000, 2'd2, 0, 1, 0, '0);
    cycle();
    idle_inputs();
    chk("ll_llbit", llbit_o, 1);
    drive_req(32'h2000, 2'd2, 1, 0, 1, 64'h1234_5678);
    #1;
    chk("sc1_valid", sc_valid_o, 1);
    chk("sc1_result", sc_result_o, 1);
    cycle();
    idle_inputs();
    chk("sc1_llbit", llbit_o, 0);
    chk("sc1_queued", dcache_req_valid, 1);
    drive_req(32'h2000, 2'd2, 1, 0, 1, 64'h1234_5678);
    #1;
    chk("sc2_valid", sc_valid_o, 1);
    chk("sc2_result", sc_result_o, 0);
    cycle();
    idle_inputs();
    chk("sc2_count", count_o, 0);
    drain();

    // Flush with a presented head and a stalled DCache
    for (int i = 0; i < 3; i++) begin
      drive_req(32'(32'h100 + i * 4), 2'd2, 0, 0, 0, '0);
      cycle();
    end
    idle_inputs();
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_count", count_o, 1);
    chk("flush_addr", dcache_addr, 32'h100);
    dcache_req_ready = 1;
    cycle();
    chk("flush_pop_count", count_o, 0);
    chk("flush_pop_valid", dcache_req_valid, 0);
    dcache_req_ready = 0;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [1:0] s;
      logic [AW-1:0] a;
      int kind;
      idle_inputs();
      in_valid = ($urandom_range(0, 99) < 70);
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 99) < 75) a = a & ~32'((1 << s) - 1);
      kind = $urandom_range(0, 9);
      in_paddr   = a;
      in_size    = s;
      in_ll      = (kind == 0);
      in_sc      = (kind == 1);
      in_we      = in_sc ? 1'b1 : (in_ll ? 1'b0 : 1'($urandom_range(0, 1)));
      in_uncache = 1'($urandom_range(0, 1));
      in_wdata   = {$urandom, $urandom};
      in_pc      = $urandom;
      flush            = ($urandom_range(0, 99) < 5);
      llbit_clear_i    = ($urandom_range(0, 99) < 3);
      dcache_req_ready = ($urandom_range(0, 99) < 50);
      cycle();
    end

    // Reset mid-burst with two entries queued and the LL bit set
    drain();
    drive_req(32'h3000, 2'd2, 0, 1, 0, '0);
    cycle();
    drive_req(32'h3008, 2'd3, 0, 0, 0, '0);
    cycle();
    idle_inputs();
    chk("pre_rst_count", count_o, 2);
    chk("pre_rst_llbit", llbit_o, 1);
    apply_reset("midrst");
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
